// File: rtl/key_input_ctrl_pkg.sv
// key_input_ctrl_pkg: shared register offsets, key count and debouncer state encoding
package KeyInputTypes;
    localparam int KEY_NUM     = 3;
    localparam int PRESS_CNT_W = 8;
    localparam logic [3:0] KEY_OFS_STATUS = 4'h0;
    localparam logic [3:0] KEY_OFS_EVENT  = 4'h4;
    localparam logic [3:0] KEY_OFS_COUNT  = 4'h8;
    typedef enum logic [1:0] {RELEASED, CHK_PRESS, PRESSED, CHK_RELEASE} deb_state_t;
endpackage

// File: rtl/key_input_ctrl_debouncer.sv
// key_debouncer: 2-flop synchroniser plus stable-count debouncer for one push-button
module key_debouncer
    import KeyInputTypes::*;
#(
    parameter int DEBOUNCE_LEN = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_LEN);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LEN - 1);

    logic [1:0]    sync_ff;
    logic          sync;
    deb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    assign sync = sync_ff[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
            state   <= RELEASED;
            cnt     <= '0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            state   <= state_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RELEASED: if (sync) begin
                state_nxt = CHK_PRESS;
                cnt_nxt   = CW'(1);
            end
            CHK_PRESS: if (!sync) begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end else if (cnt == LAST) begin
                state_nxt = PRESSED;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt   = cnt + CW'(1);
            end
            PRESSED: if (!sync) begin
                state_nxt = CHK_RELEASE;
                cnt_nxt   = CW'(1);
            end
            CHK_RELEASE: if (sync) begin
                state_nxt = PRESSED;
                cnt_nxt   = '0;
            end else if (cnt == LAST) begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt   = cnt + CW'(1);
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    // press fires in the cycle whose edge moves the FSM into PRESSED, so level/event/count land together
    always_comb begin
        press = (state == CHK_PRESS) && sync && (cnt == LAST);
        level = (state == PRESSED) || (state == CHK_RELEASE);
    end
endmodule

// File: rtl/key_input_ctrl.sv
// key_input_ctrl: memory-mapped push-button peripheral with debounced status,
// sticky press events (clear-on-read / W1C) and per-key press counters
module key_input_ctrl
    import KeyInputTypes::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0100,
    parameter int                    DEBOUNCE_LEN = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sigCH,
    input  logic                  sigCE,
    input  logic                  sigCP,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  rdEnable,
    input  logic                  wrEnable,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic                  hit,
    output logic [DATA_WIDTH-1:0] rdData
);
    logic [KEY_NUM-1:0]     raw, level, press, ev, clr;
    logic [PRESS_CNT_W-1:0] cnt [KEY_NUM];
    logic [3:0]             ofs;
    logic                   rd_ev, wr_ev;
    logic                   unused_wr_bits;

    assign raw            = {sigCP, sigCE, sigCH};
    assign unused_wr_bits = ^wrData[DATA_WIDTH-1:KEY_NUM];

    for (genvar k = 0; k < KEY_NUM; k++) begin : g_key
        key_debouncer #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw[k]),
            .level (level[k]),
            .press (press[k])
        );
    end

    assign hit   = addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    assign ofs   = addr[3:0];
    assign rd_ev = hit && rdEnable && (ofs == KEY_OFS_EVENT);
    assign wr_ev = hit && wrEnable && (ofs == KEY_OFS_EVENT);
    // a read clears everything, so it dominates a simultaneous W1C mask
    assign clr   = rd_ev ? '1 : wr_ev ? wrData[KEY_NUM-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ev <= '0;
            for (int i = 0; i < KEY_NUM; i++) cnt[i] <= '0;
        end else begin
            ev <= (ev & ~clr) | press;
            for (int i = 0; i < KEY_NUM; i++) if (press[i]) cnt[i] <= cnt[i] + PRESS_CNT_W'(1);
        end
    end

    assign rdData = !hit                  ? '0 :
                    ofs == KEY_OFS_STATUS ? DATA_WIDTH'(level) :
                    ofs == KEY_OFS_EVENT  ? DATA_WIDTH'(ev) :
                    ofs == KEY_OFS_COUNT  ? DATA_WIDTH'({cnt[2], cnt[1], cnt[0]}) : '0;
endmodule

// File: tb/tb_key_input_ctrl.sv
// tb_key_input_ctrl: directed stimulus with a run-length reference model checked every cycle
module tb_key_input_ctrl;
    localparam int          L    = 4;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 0, rst = 1;
    logic        sigCH = 0, sigCE = 0, sigCP = 0;
    logic        rdEnable = 0, wrEnable = 0;
    logic [31:0] addr = BASE, wrData = 0;
    logic        hit;
    logic [31:0] rdData;
    int          total = 0, bad = 0, idx = 0;

    always #5 clk = ~clk;

    key_input_ctrl #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .DEBOUNCE_LEN(L)
    ) dut (
        .clk(clk), .rst(rst), .sigCH(sigCH), .sigCE(sigCE), .sigCP(sigCP),
        .addr(addr), .rdEnable(rdEnable), .wrEnable(wrEnable), .wrData(wrData),
        .hit(hit), .rdData(rdData)
    );

    // model: a key's level flips once its synchronised input has disagreed with it for L straight samples
    bit m_s1 [3], m_s2 [3], m_lvl [3], m_ev [3], m_p [3], m_raw [3];
    int m_run [3], m_cnt [3];
    bit m_clr;

    function automatic bit m_hit(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[3:0])
            4'h0:    return {29'b0, m_lvl[2], m_lvl[1], m_lvl[0]};
            4'h4:    return {29'b0, m_ev[2], m_ev[1], m_ev[0]};
            4'h8:    return {8'b0, 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_ev[k] = 0; m_run[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            m_raw = '{sigCH, sigCE, sigCP};
            for (int k = 0; k < 3; k++) begin
                m_p[k] = 0;
                if (m_s2[k] != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == L) begin
                        m_lvl[k] = ~m_lvl[k];
                        m_run[k] = 0;
                        m_p[k]   = m_lvl[k];
                    end
                end else m_run[k] = 0;
                m_s2[k] = m_s1[k];
                m_s1[k] = m_raw[k];
            end
            for (int k = 0; k < 3; k++) begin
                m_clr = m_hit(addr) && addr[3:0] == 4'h4 && (rdEnable || (wrEnable && wrData[k]));
                m_ev[k] = (m_ev[k] && !m_clr) || m_p[k];
                if (m_p[k]) m_cnt[k] = (m_cnt[k] + 1) % 256;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        check("cyc_hit", 32'(hit), 32'(m_hit(addr)));
        check("cyc_rd", rdData, m_rd(addr));
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            addr = BASE + 32'(4 * (idx % 3));
            idx++;
        end
    endtask

    task automatic peek(input logic [3:0] ofs, input string nm, input logic [31:0] exp);
        addr = BASE + 32'(ofs);
        rdEnable = 0;
        wrEnable = 0;
        #1 check(nm, rdData, exp);
    endtask

    task automatic bus_rd(input logic [3:0] ofs, input string nm, input logic [31:0] exp);
        addr = BASE + 32'(ofs);
        rdEnable = 1;
        #1 check(nm, rdData, exp);
        @(negedge clk);
        rdEnable = 0;
    endtask

    task automatic bus_wr(input logic [3:0] ofs, input logic [31:0] d);
        addr = BASE + 32'(ofs);
        wrData = d;
        wrEnable = 1;
        @(negedge clk);
        wrEnable = 0;
    endtask

    task automatic pulse(input int k, input int hi, input int lo);
        if (k == 0) sigCH = 1; else if (k == 1) sigCE = 1; else sigCP = 1;
        wait_cyc(hi);
        if (k == 0) sigCH = 0; else if (k == 1) sigCE = 0; else sigCP = 0;
        wait_cyc(lo);
    endtask

    initial begin
        wait_cyc(3);
        peek(4'h0, "rst_status", 32'h0);
        peek(4'h4, "rst_event", 32'h0);
        peek(4'h8, "rst_count", 32'h0);
        rst = 0;
        sigCH = 1;
        wait_cyc(5);
        peek(4'h0, "ch_status_edge5", 32'h0);
        wait_cyc(1);
        peek(4'h0, "ch_status_edge6", 32'h1);
        peek(4'h4, "ch_event", 32'h1);
        peek(4'h8, "ch_count", 32'h1);
        bus_rd(4'h4, "ev_read_first", 32'h1);
        peek(4'h4, "ev_read_cleared", 32'h0);
        sigCH = 0;
        wait_cyc(10);
        repeat (5) pulse(1, 3, 4);
        peek(4'h0, "glitch_status", 32'h0);
        peek(4'h4, "glitch_event", 32'h0);
        peek(4'h8, "glitch_count", 32'h1);
        repeat (256) pulse(2, 7, 7);
        peek(4'h8, "wrap_count", 32'h1);
        peek(4'h4, "wrap_event", 32'h4);
        sigCH = 1;
        sigCE = 1;
        wait_cyc(8);
        sigCH = 0;
        sigCE = 0;
        wait_cyc(8);
        peek(4'h4, "event_all", 32'h7);
        peek(4'h8, "count_mix", 32'h0000_0102);
        bus_wr(4'h4, 32'h2);
        peek(4'h4, "w1c_bit1", 32'h5);
        bus_wr(4'h8, 32'hFFFF_FFFF);
        peek(4'h8, "count_ro", 32'h0000_0102);
        bus_wr(4'h0, 32'hFFFF_FFFF);
        peek(4'h0, "status_ro", 32'h0);
        bus_wr(4'h4, 32'h1);
        peek(4'h4, "w1c_bit0", 32'h4);
        sigCH = 1;
        wait_cyc(5);
        bus_rd(4'h4, "race_read_old", 32'h4);
        peek(4'h4, "race_set_wins", 32'h1);
        peek(4'h0, "race_status", 32'h1);
        peek(4'h8, "race_count", 32'h0000_0103);
        sigCH = 0;
        wait_cyc(8);
        addr = BASE + 32'h10;
        rdEnable = 1;
        wrEnable = 1;
        wrData = 32'hFFFF_FFFF;
        #1 check("miss_hit", 32'(hit), 32'h0);
        check("miss_rd", rdData, 32'h0);
        @(negedge clk);
        rdEnable = 0;
        wrEnable = 0;
        peek(4'h4, "miss_no_effect", 32'h1);
        sigCH = 1;
        wait_cyc(4);
        rst = 1;
        wait_cyc(1);
        peek(4'h0, "mid_rst_status", 32'h0);
        peek(4'h4, "mid_rst_event", 32'h0);
        peek(4'h8, "mid_rst_count", 32'h0);
        rst = 0;
        wait_cyc(5);
        peek(4'h0, "requal_edge5", 32'h0);
        wait_cyc(1);
        peek(4'h0, "requal_status", 32'h1);
        peek(4'h4, "requal_event", 32'h1);
        peek(4'h8, "requal_count", 32'h1);
        sigCH = 0;
        wait_cyc(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_input_ctrl.md
# key_input_ctrl

Memory-mapped input peripheral that samples the three board push-buttons (sigCH, sigCE, sigCP), synchronises and debounces them, and records press events and press counts. It is a data-bus responder: the CPU reads button state through the same address/data path it uses for data memory, and the top level selects `rdData` onto the CPU's read-data input when `hit` is high. It is the input-side counterpart to the 7-seg/lamp output path.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, data-bus address width
- `DATA_WIDTH`, 32, data-bus data width (≥ 24)
- `BASE_ADDR`, 32'h0000_0100, window base; 16-byte aligned
- `DEBOUNCE_LEN`, 50000, consecutive stable cycles required to accept a level change (≥ 2)

Ports:
- `clk` in 1: single clock, the CPU clock
- `rst` in 1: synchronous, active-high reset
- `sigCH`, `sigCE`, `sigCP` in 1 each: raw asynchronous buttons; 1 = pressed
- `addr` in ADDR_WIDTH: CPU data address
- `rdEnable` in 1: CPU read strobe
- `wrEnable` in 1: CPU write strobe
- `wrData` in DATA_WIDTH: CPU write data
- `hit` out 1: `addr` falls in the 16-byte window (combinational)
- `rdData` out DATA_WIDTH: read data (combinational from registers)

## Operation
- Key index: 0 = CH, 1 = CE, 2 = CP.
- Per key: 2-flop synchroniser, then debouncer FSM with states RELEASED, CHK_PRESS, PRESSED, CHK_RELEASE.
  - RELEASED: sync = 1 → CHK_PRESS, counter = 1.
  - CHK_PRESS: sync = 0 → RELEASED, counter = 0. Counter = DEBOUNCE_LEN−1 with sync = 1 → PRESSED and a one-cycle `press` pulse. Otherwise counter+1.
  - PRESSED / CHK_RELEASE: mirror of the above, with no event pulse.
  - Debounced level = 1 in PRESSED and CHK_RELEASE.
- Register map (offset = addr[3:0]):
  - 0x0 STATUS, RO: bits[2:0] debounced levels; other bits 0.
  - 0x4 EVENT, sticky press flags in bits[2:0]. A read clears all flags. Writing 1 to a bit clears that bit.
  - 0x8 COUNT, RO: {8'b0, cp[7:0], ce[7:0], ch[7:0]}. Each 8-bit counter increments on its `press` pulse and wraps 255 → 0.
  - 0xC: reserved; reads 0, writes ignored.
- `hit` = (addr[ADDR_WIDTH−1:4] == BASE_ADDR[ADDR_WIDTH−1:4]).
- When `hit` = 0: `rdData` = 0 and there are no side effects.
- Writes to STATUS/COUNT are ignored.
- Simultaneous `press` and clear (read or W1C) of the same EVENT bit: the bit ends at 1 (set wins). The read in that cycle returns the pre-clear value.
- `rdEnable` and `wrEnable` both high at EVENT: the read returns the old value, then all flags clear. Set-wins still applies.

## Timing
- Reset: `rdData` = 0 when not addressed. All sync flops 0, FSMs in RELEASED, levels 0, events 0, counters 0.
- Press latency: a raw 0→1 held stable reaches the STATUS level after exactly 2 + DEBOUNCE_LEN rising edges. The EVENT bit and counter update on the same edge.
- Release latency: identical; no event.
- Glitch shorter than DEBOUNCE_LEN cycles (after sync) produces no level change.
- Read side effects (clear-on-read) take effect at the rising edge ending the cycle in which `rdEnable && hit && offset==0x4`.
- Reset asserted mid-debounce abandons the check. A key still held after reset is re-qualified as a new press after 2 + DEBOUNCE_LEN cycles.

## Structure
- Package `KeyInputTypes`:
  - register offsets (`KEY_OFS_STATUS/EVENT/COUNT`)
  - `KEY_NUM = 3`
  - debouncer state enum
  - press-counter width (8)
- Sub-module `key_debouncer` (sync + FSM + counter; outputs `level`, `press`), instantiated 3×.
- Top holds event/count registers and the bus decode.

## Test plan
- DEBOUNCE_LEN = 4, reset released, sigCH held 1 → STATUS = 0x1 and EVENT = 0x1 after 6 edges. COUNT = 0x000001. The EVENT read returns 0x1, and the next read returns 0x0.
- sigCE pulses 1 for 3 cycles, repeated 5× with gaps → STATUS, EVENT, and COUNT stay 0.
- sigCP pressed/released 256× → COUNT[23:16] = 0x00 and EVENT bit2 = 1 (wrap).
- Write 0x2 to EVENT with EVENT = 0x7 → EVENT = 0x5. A write of 0xFFFFFFFF to COUNT leaves it unchanged.
- EVENT read on the same edge as a new CH press → read returns the old value and bit0 remains 1 afterwards.
- `addr` = BASE_ADDR+0x10 with `rdEnable` → `hit` = 0, `rdData` = 0, EVENT unchanged. `rst` pulsed mid-CHK_PRESS while CH is held → all registers 0, then the press is re-qualified 6 edges after reset.
